scan_loader: RTL and testbench

SCAN_LOADER -- requirements
Module: scan_loader

---
 rtl/scan_loader.sv | 118 +++++++++++
 tb/tb_scan_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_loader.sv
// Purpose: turns host configuration bytes into serial scan-chain programming, with an optional verify mode.
// Latency: start to done is 1 + ceil(CHAIN_LEN/8) + CHAIN_LEN + 1 cycles when in_valid is held high.
// Backpressure: in_ready is high only in FETCH, and the chain holds (scan_en low) while the host stalls.
module scan_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       verify,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_scan_in,
    output logic       cfg_scan_en,
    input  logic       cfg_scan_out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counter value during the last shift of a pass.
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           sr_q, sr_d;
    logic                 mode_q, mode_d;
    logic                 err_q, err_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;

    // Next-state logic: pass sequencing, byte shifting and verify compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = verify;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    idx_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = {1'b0, sr_q[7:1]};
                idx_d = idx_q + 3'd1;
                cnt_d = cnt_q + 1'b1;
                // The chain tail carries the bit loaded at this same position last pass.
                if (mode_q && (cfg_scan_out != scan_in_q)) begin
                    err_d = 1'b1;
                end
                // Chain-length exit wins, so leftover bits of a partial last byte are dropped.
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end else if (idx_q == 3'd7) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Scan outputs are registered: they show the bit for the cycle being entered.
        scan_en_d = (state_d == S_SHIFT);
        scan_in_d = (state_d == S_SHIFT) ? sr_d[0] : 1'b0;
    end

    // State registers; reset aborts a pass immediately and drops scan_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sr_q      <= 8'd0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
        end
    end

    assign in_ready    = (state_q == S_FETCH);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign error       = err_q;
    assign cfg_scan_en = scan_en_q;
    assign cfg_scan_in = scan_in_q;

endmodule

// File: tb/tb_scan_loader.sv
// Purpose: directed bench for scan_loader with a fabric chain model and a bit-level scoreboard.
// Latency: checks start-to-done timing with and without host stalls.
// Backpressure: the host feeder can hold in_valid low while the loader waits in FETCH.
module tb_scan_loader;

    localparam int CL = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       verify = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, cfg_scan_in, cfg_scan_en, cfg_scan_out, busy, done, error;

    scan_loader #(.CHAIN_LEN(CL), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .verify       (verify),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_scan_in  (cfg_scan_in),
        .cfg_scan_en  (cfg_scan_en),
        .cfg_scan_out (cfg_scan_out),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fabric scan chain: head takes scan_in, tail drives scan_out.
    logic [CL-1:0] chain = '0;
    int            fab_shifts = 0;
    assign cfg_scan_out = chain[CL-1];
    always @(posedge clk) begin
        if (cfg_scan_en) begin
            chain      <= {chain[CL-2:0], cfg_scan_in};
            fab_shifts <= fab_shifts + 1;
        end
    end

    // Model: bit k of a pass is bit (k mod 8) of byte k/8; verify flags any
    // position where the new bit differs from the one loaded last pass.
    logic exp_bits[CL];
    logic prev_bits[CL];
    logic vmode_m = 1'b0;
    int   pass_base = 0;
    int   seen = 0;

    function automatic logic exp_err(input int k);
        logic e;
        e = 1'b0;
        for (int j = 0; j < k; j++) begin
            if (vmode_m && (prev_bits[j] !== exp_bits[j])) e = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard: every shift cycle must carry the expected bit and error state.
    always @(negedge clk) begin
        if (!rst && cfg_scan_en) begin
            if (seen - pass_base < CL) begin
                chk("scan_bit", {31'd0, cfg_scan_in}, {31'd0, exp_bits[seen - pass_base]});
                chk("error_mid_pass", {31'd0, error}, {31'd0, exp_err(seen - pass_base)});
            end else begin
                chk("extra_shift", seen - pass_base, CL - 1);
            end
            seen <= seen + 1;
        end
    end

    task automatic run_pass(input logic vm, input logic [7:0] b0, input logic [7:0] b1,
                            input int stall, input int rst_at, input logic noise, output int lat);
        int acc;
        int stall_left;
        int fab_base;
        acc        = 0;
        stall_left = stall;
        lat        = -1;
        if (noise) begin
            @(posedge clk); #2;
            in_valid = 1'b1;
            in_data  = 8'hFF;
            #2 chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #2;
            in_valid = 1'b0;
            chk("idle_in_valid_ignored", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #2;
        vmode_m = vm;
        for (int k = 0; k < CL; k++) exp_bits[k] = (k < 8) ? b0[k] : b1[k-8];
        pass_base = seen;
        fab_base  = fab_shifts;
        verify    = vm;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #2;
            end
            start = (cyc == 0) || (noise && cyc == 5);
            if (cyc == 1) begin
                chk("error_cleared_on_start", {31'd0, error}, 32'd0);
                chk("busy_in_fetch", {31'd0, busy}, 32'd1);
            end
            if (cyc > 0 && done) begin
                lat = cyc;
                break;
            end
            if (rst_at > 0 && cfg_scan_en && (seen - pass_base == rst_at - 1)) begin
                rst = 1'b1;
                #1 chk("reset_outputs_async",
                       {26'd0, cfg_scan_en, cfg_scan_in, in_ready, busy, done, error}, 32'd0);
                @(posedge clk); #2;
                chk("reset_shift_count", fab_shifts - fab_base, rst_at - 1);
                rst      = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #2;
                chk("reset_fsm_idle", {31'd0, busy}, 32'd0);
                return;
            end
            if (acc == 1 && in_ready && stall_left > 0) begin
                stall_left--;
                in_valid = 1'b0;
                chk("stall_scan_en_low", {31'd0, cfg_scan_en}, 32'd0);
            end else begin
                in_valid = (acc < 2);
            end
            in_data = (acc == 0) ? b0 : b1;
            #2;
            if (in_ready && in_valid) acc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("shift_count", seen - pass_base, CL);
        chk("fabric_shift_count", fab_shifts - fab_base, CL);
        chk("error_at_done", {31'd0, error}, {31'd0, exp_err(CL)});
        for (int k = 0; k < CL; k++) prev_bits[k] = exp_bits[k];
        @(posedge clk); #2;
        chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    endtask

    int            lat;
    logic [CL-1:0] pk;

    initial begin
        for (int k = 0; k < CL; k++) begin
            prev_bits[k] = 1'b0;
            exp_bits[k]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2 chk("reset_state", {26'd0, cfg_scan_en, cfg_scan_in, in_ready, busy, done, error}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("idle_after_reset", {26'd0, cfg_scan_en, cfg_scan_in, in_ready, busy, done, error}, 32'd0);

        // Load A5,0F: done shows in cycle 15 after the start cycle (16 cycles inclusive).
        run_pass(1'b0, 8'hA5, 8'h0F, 0, 0, 1'b0, lat);
        chk("load_latency", lat, 15);
        for (int k = 0; k < CL; k++) pk[CL-1-k] = exp_bits[k];
        chk("model_bit_sequence", {20'd0, pk}, 32'hA5F);
        chk("chain_after_load", {20'd0, chain}, 32'hA5F);
        chk("load_error", {31'd0, error}, 32'd0);

        // Matching verify leaves the chain unchanged.
        run_pass(1'b1, 8'hA5, 8'h0F, 0, 0, 1'b0, lat);
        chk("verify_latency", lat, 15);
        chk("verify_match_error", {31'd0, error}, 32'd0);
        chk("chain_after_verify", {20'd0, chain}, 32'hA5F);

        // Mismatch at bit 8; error is sticky until the next start.
        run_pass(1'b1, 8'hA5, 8'h0E, 0, 0, 1'b0, lat);
        chk("verify_mismatch_error", {31'd0, error}, 32'd1);
        chk("chain_after_mismatch", {20'd0, chain}, 32'hA57);
        repeat (3) @(posedge clk);
        #2 chk("error_sticky", {31'd0, error}, 32'd1);

        // Five stalled FETCH cycles between the bytes.
        run_pass(1'b0, 8'hA5, 8'h0F, 5, 0, 1'b0, lat);
        chk("stall_latency", lat, 20);
        chk("chain_after_stall", {20'd0, chain}, 32'hA5F);
        chk("load_clears_error_via_start", {31'd0, error}, 32'd0);

        // Reset during the 6th shift: only bits 0..4 of 0x3C (0,0,1,1,1) enter.
        run_pass(1'b0, 8'h3C, 8'h81, 0, 6, 1'b0, lat);
        chk("chain_after_reset", {20'd0, chain}, 32'hBE7);

        // Clean pass with stray start in SHIFT and stray in_valid in IDLE.
        run_pass(1'b0, 8'h3C, 8'h81, 0, 0, 1'b1, lat);
        chk("noise_latency", lat, 15);
        chk("chain_after_noise", {20'd0, chain}, 32'h3C8);

        run_pass(1'b1, 8'h3C, 8'h81, 0, 0, 1'b0, lat);
        chk("verify2_error", {31'd0, error}, 32'd0);
        chk("chain_after_verify2", {20'd0, chain}, 32'h3C8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
